// File: rtl/uart8_tx.sv
// uart8_tx: 8N1 UART transmitter, LSB first, one bit every CLOCK_RATE/BAUD_RATE clocks.
// Define UART8_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
`timescale 1ns/1ps
module uart8_tx #(
  parameter int CLOCK_RATE = 12000000,
  parameter int BAUD_RATE  = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       txEn,
  input  logic       txStart,
  input  logic [7:0] in,
  output logic       out,
  output logic       txBusy,
  output logic       txDone
);

  localparam int DIV = CLOCK_RATE / BAUD_RATE;
  localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [CW-1:0] C_ZERO = CW'(0);
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [CW-1:0] C_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] C_PRE  = CW'(DIV - 2);

  generate
    if (DIV < 2) begin : g_div_check
      $error("uart8_tx: CLOCK_RATE / BAUD_RATE must be at least 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3
`ifdef UART8_TX_PARITY_EN
    , S_PARITY = 3'd4
`endif
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_out;
  logic          r_busy;
  logic          r_done;
`ifdef UART8_TX_PARITY_EN
  logic          r_par;

  function automatic logic f_even_parity(input logic [7:0] d);
    return ^d;
  endfunction
`endif

  logic w_accept;
  logic w_last;

  assign w_accept = txEn & txStart;
  assign w_last   = (r_cnt == C_LAST);

  // Frame sequencer; out holds the value for the cycle that follows each edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= C_ZERO;
      r_bit   <= 3'd0;
      r_shift <= 8'd0;
      r_out   <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef UART8_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      r_cnt  <= w_last ? C_ZERO : (r_cnt + C_ONE);
      case (r_state)
        S_IDLE: begin
          r_cnt  <= C_ZERO;
          r_out  <= 1'b1;
          r_busy <= 1'b0;
          if (w_accept) begin
            r_state <= S_START;
            r_shift <= in;
            r_bit   <= 3'd0;
            r_out   <= 1'b0;
            r_busy  <= 1'b1;
`ifdef UART8_TX_PARITY_EN
            r_par   <= f_even_parity(in);
`endif
          end
        end
        S_START: begin
          if (w_last) begin
            r_state <= S_DATA;
            r_bit   <= 3'd0;
            r_out   <= r_shift[0];
          end
        end
        S_DATA: begin
          if (w_last) begin
            r_shift <= {1'b0, r_shift[7:1]};
            if (r_bit == 3'd7) begin
`ifdef UART8_TX_PARITY_EN
              r_state <= S_PARITY;
              r_out   <= r_par;
`else
              r_state <= S_STOP;
              r_out   <= 1'b1;
`endif
            end else begin
              r_bit <= r_bit + 3'd1;
              r_out <= r_shift[1];
            end
          end
        end
`ifdef UART8_TX_PARITY_EN
        S_PARITY: begin
          if (w_last) begin
            r_state <= S_STOP;
            r_out   <= 1'b1;
          end
        end
`endif
        S_STOP: begin
          // Raised one cycle early so the registered pulse lands on the final stop cycle.
          if (r_cnt == C_PRE) begin
            r_done <= 1'b1;
          end
          if (w_last) begin
            if (w_accept) begin
              r_state <= S_START;
              r_shift <= in;
              r_bit   <= 3'd0;
              r_out   <= 1'b0;
              r_busy  <= 1'b1;
`ifdef UART8_TX_PARITY_EN
              r_par   <= f_even_parity(in);
`endif
            end else begin
              r_state <= S_IDLE;
              r_out   <= 1'b1;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= C_ZERO;
          r_out   <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign out    = r_out;
  assign txBusy = r_busy;
  assign txDone = r_done;

endmodule

// File: tb/tb_uart8_tx.sv
// Self-checking bench for uart8_tx using a reduced divider (100/8 -> 12, truncated).
// Expected line levels come from a per-cycle frame model built from the byte alone.
`timescale 1ns/1ps
module tb_uart8_tx;

  localparam int CLK_HZ = 100;
  localparam int BAUD   = 8;
  localparam int DIV    = CLK_HZ / BAUD;
`ifdef UART8_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * DIV;
  localparam int MAXC  = 2 * FRAME + 4 * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       txEn = 1'b0;
  logic       txStart = 1'b0;
  logic [7:0] in = 8'h00;
  logic       out;
  logic       txBusy;
  logic       txDone;

  int n_checks = 0;
  int n_errors = 0;

  logic s_out  [0:MAXC-1];
  logic s_busy [0:MAXC-1];
  logic s_done [0:MAXC-1];

  always #5 clk = ~clk;

  uart8_tx #(.CLOCK_RATE(CLK_HZ), .BAUD_RATE(BAUD)) dut (
    .clk(clk), .rst(rst), .txEn(txEn), .txStart(txStart), .in(in),
    .out(out), .txBusy(txBusy), .txDone(txDone)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Record n cycles of outputs starting at array index first.
  task automatic sample_cycles(input int first, input int n);
    for (int k = 0; k < n; k++) begin
      s_out[first + k]  = out;
      s_busy[first + k] = txBusy;
      s_done[first + k] = txDone;
      tick();
    end
  endtask

  function automatic logic exp_line(input logic [7:0] b, input int c);
    int pos;
    pos = c / DIV;
    if (pos == 0) return 1'b0;
    else if (pos <= 8) return b[pos - 1];
    else if (pos == NB - 1) return 1'b1;
    else return ^b;
  endfunction

  function automatic int frame_errs(input logic [7:0] b, input int base);
    int e;
    e = 0;
    for (int c = 0; c < FRAME; c++) begin
      if (s_out[base + c] !== exp_line(b, c)) e++;
      if (s_busy[base + c] !== 1'b1) e++;
      if (s_done[base + c] !== (c == FRAME - 1)) e++;
    end
    return e;
  endfunction

  function automatic logic [7:0] decode(input int base);
    logic [7:0] d;
    for (int i = 0; i < 8; i++) d[i] = s_out[base + (i + 1) * DIV + DIV / 2];
    return d;
  endfunction

  task automatic test_reset();
    rst = 1'b1; txEn = 1'b1; txStart = 1'b1; in = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({out, txBusy, txDone} !== 3'b100) begin
        n_errors++;
        $display("FAIL reset_hold cycle %0d got out/busy/done=%b%b%b want 100", i, out, txBusy, txDone);
      end
    end
    rst = 1'b0; txStart = 1'b0;
    tick();
    n_checks++;
    if ({out, txBusy, txDone} !== 3'b100) begin
      n_errors++;
      $display("FAIL reset_release got out/busy/done=%b%b%b want 100", out, txBusy, txDone);
    end
  endtask

  task automatic test_single();
    int e;
    int di;
    txEn = 1'b1; in = 8'b01010110; txStart = 1'b1;
    tick();
    txStart = 1'b0; in = 8'hFF;
    sample_cycles(0, FRAME + 1);
    e = frame_errs(8'h56, 0);
    n_checks++;
    if (e !== 0) begin
      n_errors++;
      $display("FAIL single_frame got %0d mismatching samples want 0", e);
    end
    n_checks++;
    if (decode(0) !== 8'h56) begin
      n_errors++;
      $display("FAIL single_decode got %h want 56", decode(0));
    end
    di = -1;
    for (int c = FRAME; c >= 0; c--) if (s_done[c] === 1'b1) di = c;
    n_checks++;
    if (di !== FRAME - 1) begin
      n_errors++;
      $display("FAIL single_done_cycle got %0d want %0d", di, FRAME - 1);
    end
    n_checks++;
    if ({s_out[FRAME], s_busy[FRAME], s_done[FRAME]} !== 3'b100) begin
      n_errors++;
      $display("FAIL single_after got out/busy/done=%b%b%b want 100", s_out[FRAME], s_busy[FRAME], s_done[FRAME]);
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    int e;
    for (int f = 0; f < 5; f++) begin
      b = 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, 3)) tick();
      in = b; txStart = 1'b1;
      tick();
      txStart = 1'b0; in = 8'($urandom);
      sample_cycles(0, FRAME + 1);
      e = frame_errs(b, 0);
      n_checks++;
      if (e !== 0 || s_busy[FRAME] !== 1'b0) begin
        n_errors++;
        $display("FAIL random_frame byte %h got %0d mismatches busy_after=%b want 0 and 0", b, e, s_busy[FRAME]);
      end
      n_checks++;
      if (decode(0) !== b) begin
        n_errors++;
        $display("FAIL random_decode got %h want %h", decode(0), b);
      end
    end
  endtask

  task automatic test_back_to_back();
    int e1;
    int e2;
    int npulse;
    txStart = 1'b1; in = 8'h56;
    tick();
    in = 8'hA5;
    sample_cycles(0, FRAME);
    txStart = 1'b0; in = 8'($urandom);
    sample_cycles(FRAME, FRAME + 1);
    e1 = frame_errs(8'h56, 0);
    e2 = frame_errs(8'hA5, FRAME);
    n_checks++;
    if (e1 !== 0 || e2 !== 0) begin
      n_errors++;
      $display("FAIL b2b_frames got %0d and %0d mismatches want 0 and 0", e1, e2);
    end
    npulse = 0;
    for (int c = 0; c <= 2 * FRAME; c++) if (s_done[c] === 1'b1) npulse++;
    n_checks++;
    if (npulse !== 2) begin
      n_errors++;
      $display("FAIL b2b_done_count got %0d want 2", npulse);
    end
    n_checks++;
    if (s_out[FRAME] !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_gapless got out=%b after stop want 0", s_out[FRAME]);
    end
    n_checks++;
    if (s_busy[2 * FRAME] !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_busy_end got %b want 0", s_busy[2 * FRAME]);
    end
  endtask

  task automatic test_busy_request();
    int e;
    int idle_bad;
    in = 8'h56; txStart = 1'b1;
    tick();
    txStart = 1'b0;
    sample_cycles(0, 4 * DIV + 2);
    txStart = 1'b1; in = 8'hFF;
    sample_cycles(4 * DIV + 2, 1);
    txStart = 1'b0;
    sample_cycles(4 * DIV + 3, FRAME - 4 * DIV - 3 + 2 * DIV);
    e = frame_errs(8'h56, 0);
    n_checks++;
    if (e !== 0) begin
      n_errors++;
      $display("FAIL busy_req_frame got %0d mismatches want 0", e);
    end
    idle_bad = 0;
    for (int c = FRAME; c < FRAME + 2 * DIV; c++)
      if ({s_out[c], s_busy[c], s_done[c]} !== 3'b100) idle_bad++;
    n_checks++;
    if (idle_bad !== 0) begin
      n_errors++;
      $display("FAIL busy_req_no_second got %0d non-idle cycles want 0", idle_bad);
    end
  endtask

  task automatic test_txen_off();
    logic [7:0] b;
    int e;
    int idle_bad;
    b = 8'($urandom_range(0, 255));
    txEn = 1'b1; in = b; txStart = 1'b1;
    tick();
    txEn = 1'b0;
    sample_cycles(0, FRAME + 2 * DIV);
    e = frame_errs(b, 0);
    n_checks++;
    if (e !== 0) begin
      n_errors++;
      $display("FAIL txen_off_frame byte %h got %0d mismatches want 0", b, e);
    end
    idle_bad = 0;
    for (int c = FRAME; c < FRAME + 2 * DIV; c++)
      if ({s_out[c], s_busy[c], s_done[c]} !== 3'b100) idle_bad++;
    n_checks++;
    if (idle_bad !== 0) begin
      n_errors++;
      $display("FAIL txen_off_idle got %0d non-idle cycles want 0", idle_bad);
    end
    txStart = 1'b0; txEn = 1'b1;
  endtask

  task automatic test_mid_reset();
    logic [7:0] b;
    int bad;
    int e;
    in = 8'h56; txStart = 1'b1;
    tick();
    txStart = 1'b0;
    sample_cycles(0, 5 * DIV + 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({out, txBusy, txDone} !== 3'b100) begin
      n_errors++;
      $display("FAIL midreset_next got out/busy/done=%b%b%b want 100", out, txBusy, txDone);
    end
    sample_cycles(0, FRAME);
    bad = 0;
    for (int c = 0; c < FRAME; c++)
      if ({s_out[c], s_busy[c], s_done[c]} !== 3'b100) bad++;
    n_checks++;
    if (bad !== 0) begin
      n_errors++;
      $display("FAIL midreset_quiet got %0d non-idle cycles want 0", bad);
    end
    b = 8'($urandom_range(0, 255));
    in = b; txStart = 1'b1;
    tick();
    txStart = 1'b0;
    sample_cycles(0, FRAME + 1);
    e = frame_errs(b, 0);
    n_checks++;
    if (e !== 0 || s_busy[FRAME] !== 1'b0) begin
      n_errors++;
      $display("FAIL midreset_clean byte %h got %0d mismatches want 0", b, e);
    end
  endtask

`ifdef UART8_TX_PARITY_EN
  task automatic test_parity();
    logic [7:0] bytes [0:1];
    logic       want  [0:1];
    bytes[0] = 8'h56; want[0] = 1'b0;
    bytes[1] = 8'h57; want[1] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in = bytes[i]; txStart = 1'b1;
      tick();
      txStart = 1'b0;
      sample_cycles(0, FRAME + 1);
      n_checks++;
      if (s_out[9 * DIV + DIV / 2] !== want[i]) begin
        n_errors++;
        $display("FAIL parity_bit byte %h got %b want %b", bytes[i], s_out[9 * DIV + DIV / 2], want[i]);
      end
      n_checks++;
      if (s_done[11 * DIV - 1] !== 1'b1 || s_done[10 * DIV - 1] !== 1'b0) begin
        n_errors++;
        $display("FAIL parity_done byte %h got done@11DIV=%b done@10DIV=%b want 1 0", bytes[i], s_done[11 * DIV - 1], s_done[10 * DIV - 1]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_random();
    test_back_to_back();
    test_busy_request();
    test_txen_off();
    test_mid_reset();
`ifdef UART8_TX_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart8_tx.md
Name: uart8_tx

Overview:
- 8N1 UART transmitter: serialises one byte per frame onto a single line, LSB first, at BAUD_RATE derived from CLOCK_RATE.
- It is the transmit-side counterpart to the Uart8 receive path and shares its clock domain.
- Output is directly loopback-compatible with the Uart8 rx input.

Parameters:
- CLOCK_RATE, 12000000: system clock frequency in Hz.
- BAUD_RATE, 9600: line bit rate in bit/s.
- Derived constant, not a parameter: DIV = CLOCK_RATE / BAUD_RATE.
  - Integer, truncated.
  - Equals 1250 at the defaults.
  - Elaboration error if DIV < 2.
  - Bit-period counter width is $clog2(DIV).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- txEn  input  1  transmit enable; gates acceptance of new frames only.
- txStart  input  1  request to send `in`; level-sampled.
- in  input  8  byte to send; latched on acceptance.
- out  output  1  serial line; idles high.
- txBusy  output  1  high from acceptance through the last stop-bit cycle.
- txDone  output  1  one-cycle pulse in the last cycle of the stop bit.

Behaviour:
- Reset: rst sampled high on a clk edge.
  - After that edge: out=1, txBusy=0, txDone=0, state=IDLE, bit counter=0, period counter=0, shift register=0.
  - Reset mid-frame aborts the frame immediately; no txDone is produced.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - out=1, txBusy=0.
  - If txEn && txStart: latch `in` into the shift register and go to START.
  - Latency: out falls on the edge after the sampling edge.
- START: out=0 for exactly DIV cycles, then go to DATA with bit index 0.
- DATA:
  - out = shift[0] for DIV cycles per bit, LSB first.
  - After each bit period: shift right and increment the index.
  - After bit 7 completes, go to STOP.
- STOP: out=1 for DIV cycles.
  - txDone=1 only in the final (DIV-th) cycle of the stop bit.
  - In that same final cycle, if txEn && txStart: latch `in` and go straight to START. This gives gapless back-to-back frames, and txBusy stays high.
  - Otherwise go to IDLE, and txBusy drops on the next edge.
- Period counter:
  - Counts 0..DIV-1 and wraps to 0 on every bit boundary.
  - Cleared on frame acceptance.
- Request handling:
  - txStart while busy, outside the last stop cycle: ignored, not queued.
  - Changes to `in` after acceptance: no effect on the current frame.
- txEn deasserted mid-frame: the current frame completes normally, including txDone; no new frame is accepted.
- Frame length without the optional feature: 10*DIV cycles from out falling to the end of the stop bit.
- All outputs are registered; out is glitch-free.

Optional Feature:
- Macro: UART8_TX_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP.
  - out = XOR of the 8 latched data bits (even parity) for DIV cycles.
  - Frame is 11*DIV cycles; txDone remains in the last stop cycle.
  - The parity value is computed from the latched byte at acceptance, not from the shifting register.
- When undefined: no parity state or logic exists; frame is 8N1, 10*DIV cycles.

Test Plan:
- Reset: rst=1 for 3 cycles with txStart=1 and in=8'hFF.
  - Required: out=1, txBusy=0, txDone=0 throughout and on the first cycle after rst falls with txStart=0.
- Single frame: in=8'b01010110, txEn=1, txStart pulsed 1 cycle (defaults, DIV=1250).
  - out=0 starting the next cycle for 1250 cycles.
  - Then data bits 0,1,1,0,1,0,1,0, each 1250 cycles.
  - Then out=1 for 1250 cycles.
  - txDone high exactly at cycle 12500 after out fell; txBusy low the cycle after.
  - Loopback into Uart8 rx gives out=8'h56 with rxErr=0.
- Back-to-back: txStart held high, in=8'h56 then 8'hA5 after acceptance.
  - Second start bit begins on the cycle immediately after the 1250th stop cycle, with no extra high cycle.
  - txBusy never drops between frames; there are two txDone pulses 12500 cycles apart.
- Busy request: during frame 8'h56, pulse txStart with in=8'hFF at data bit 3.
  - Transmitted bits are unchanged and no second frame follows.
  - With txEn=0 after acceptance, the frame still completes and txDone pulses.
- Reset mid-frame: assert rst during data bit 4.
  - Next cycle: out=1, txBusy=0.
  - No txDone ever; a new txStart after reset produces a clean full frame.
- Parity (UART8_TX_PARITY_EN defined):
  - in=8'h56 (four ones) → parity bit 0.
  - in=8'h57 (five ones) → parity bit 1.
  - txDone at cycle 13750.
